// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: owns the PC, addresses the 64-word instruction
// memory and hands each fetched word to decode through a valid/ready IF/ID slot.
module fetch_unit #(
   parameter int          PC_W      = 8,
   parameter logic [7:0]  RESET_PC  = 8'h00,
   parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [5:0]      imem_addr,
   input  logic [31:0]     imem_data,
   output logic [31:0]     id_instr,
   output logic [PC_W-1:0] id_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic            halted
);

   // state  | meaning
   // S_IDLE | out of reset, waiting for start (or a redirect); no fetch
   // S_RUN  | fetching one word per cycle whenever the IF/ID slot is free
   // S_HALT | sentinel word seen; PC frozen until redirect or reset
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt;
   logic [31:0]     instr_nxt;
   logic [PC_W-1:0] idpc_nxt;
   logic            valid_nxt;

   logic slot_free;
   logic consumed;
   logic is_halt_word;

   assign imem_addr    = pc[7:2];
   assign halted       = (state == S_HALT);
   assign slot_free    = !id_valid || id_ready;
   assign consumed     = id_valid && id_ready;
   assign is_halt_word = (imem_data == HALT_WORD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pc       <= PC_W'(RESET_PC);
         id_instr <= '0;
         id_pc    <= '0;
         id_valid <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         id_instr <= instr_nxt;
         id_pc    <= idpc_nxt;
         id_valid <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      instr_nxt = id_instr;
      idpc_nxt  = id_pc;
      valid_nxt = id_valid && !consumed;

      if (redirect) begin
         // Flush the wrong-path word; word-align the target.
         pc_nxt    = {redirect_pc[PC_W-1:2], 2'b00};
         valid_nxt = 1'b0;
         state_nxt = S_RUN;
      end else if (!stall) begin
         unique case (state)
            S_IDLE: begin
               if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
               if (slot_free) begin
                  if (is_halt_word) begin
                     // Sentinel is never forwarded; the slot has drained or was empty.
                     state_nxt = S_HALT;
                     valid_nxt = 1'b0;
                  end else begin
                     instr_nxt = imem_data;
                     idpc_nxt  = pc;
                     valid_nxt = 1'b1;
                     pc_nxt    = pc + PC_W'(4);
                  end
               end else begin
                  valid_nxt = id_valid;
               end
            end
            S_HALT: begin
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through fetch, halt, backpressure, redirect,
// wrap and async reset, then randomized traffic, all against a cycle-level model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [7:0]  redirect_pc = 8'h00;
   logic [5:0]  imem_addr;
   logic [31:0] imem_data;
   logic [31:0] id_instr;
   logic [7:0]  id_pc;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic        halted;

   logic [31:0] mem [64];
   assign imem_data = mem[imem_addr];

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .id_instr   (id_instr),
      .id_pc      (id_pc),
      .id_valid   (id_valid),
      .id_ready   (id_ready),
      .halted     (halted)
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: mode 0=idle 1=running 2=halted.
   int          m_mode;
   logic [7:0]  m_pc;
   logic [31:0] m_instr;
   logic [7:0]  m_idpc;
   logic        m_valid;

   task automatic model_reset();
      m_mode = 0; m_pc = 8'h00; m_instr = 0; m_idpc = 0; m_valid = 0;
   endtask

   task automatic model_step(input logic s, input logic st, input logic rd,
                             input logic [7:0] rpc, input logic rdy);
      logic [31:0] w;
      if (rd) begin
         m_pc    = rpc & 8'hFC;
         m_valid = 0;
         m_mode  = 1;
      end else if (st) begin
         if (rdy) m_valid = 0;
      end else if (m_mode == 0) begin
         if (s) m_mode = 1;
      end else if (m_mode == 1) begin
         if (!m_valid || rdy) begin
            w = mem[m_pc / 4];
            if (w == 32'h0) begin
               m_mode  = 2;
               m_valid = 0;
            end else begin
               m_instr = w;
               m_idpc  = m_pc;
               m_valid = 1;
               m_pc    = m_pc + 8'd4;
            end
         end
      end else begin
         if (rdy) m_valid = 0;
      end
   endtask

   task automatic compare_all(input string tag);
      chk({tag, ".valid"}, 64'(id_valid), 64'(m_valid));
      chk({tag, ".halted"}, 64'(halted), 64'(m_mode == 2));
      chk({tag, ".addr"}, 64'(imem_addr), 64'(m_pc / 4));
      if (m_valid) begin
         chk({tag, ".instr"}, 64'(id_instr), 64'(m_instr));
         chk({tag, ".idpc"}, 64'(id_pc), 64'(m_idpc));
      end
   endtask

   task automatic step(input string tag, input logic s, input logic st, input logic rd,
                       input logic [7:0] rpc, input logic rdy);
      @(negedge clk);
      start = s; stall = st; redirect = rd; redirect_pc = rpc; id_ready = rdy;
      model_step(s, st, rd, rpc, rdy);
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
      mem[0] = 32'h8B1F03E5; mem[1] = 32'hF84000A4;
      mem[2] = 32'h8B040086; mem[3] = 32'hF80010A6;
      mem[4] = 32'h0000_0000; mem[63] = 32'h8B1F03E5;
      model_reset();

      #12;
      chk("rst.valid", 64'(id_valid), 64'h0);
      chk("rst.instr", 64'(id_instr), 64'h0);
      chk("rst.idpc", 64'(id_pc), 64'h0);
      chk("rst.halted", 64'(halted), 64'h0);
      chk("rst.addr", 64'(imem_addr), 64'h0);
      @(negedge clk); rst_n = 1'b1;

      step("idle", 0, 0, 0, 8'h00, 1);
      step("start", 1, 0, 0, 8'h00, 1);
      step("f0", 0, 0, 0, 8'h00, 1);
      chk("f0.instr", 64'(id_instr), 64'h8B1F03E5);
      step("f1", 0, 0, 0, 8'h00, 1);
      chk("f1.instr", 64'(id_instr), 64'hF84000A4);
      step("f2", 0, 0, 0, 8'h00, 1);
      chk("f2.instr", 64'(id_instr), 64'h8B040086);
      step("f3", 0, 0, 0, 8'h00, 1);
      chk("f3.idpc", 64'(id_pc), 64'h0C);
      step("halt", 0, 0, 0, 8'h00, 1);
      chk("halt.halted", 64'(halted), 64'h1);
      chk("halt.addr", 64'(imem_addr), 64'h4);
      step("halt_start", 1, 0, 0, 8'h00, 1);
      step("halt_hold", 0, 0, 0, 8'h00, 1);

      // Redirect out of HALT, then backpressure on the second word.
      step("redir0", 0, 0, 1, 8'h00, 1);
      chk("redir0.halted", 64'(halted), 64'h0);
      step("bp_a", 0, 0, 0, 8'h00, 1);
      step("bp_b", 0, 0, 0, 8'h00, 1);
      for (int i = 0; i < 5; i++) begin
         step("bp_hold", 0, 0, 0, 8'h00, 0);
         chk("bp.instr", 64'(id_instr), 64'hF84000A4);
         chk("bp.idpc", 64'(id_pc), 64'h04);
         chk("bp.addr", 64'(imem_addr), 64'h2);
      end
      step("bp_rel", 0, 0, 0, 8'h00, 1);
      chk("bp_rel.instr", 64'(id_instr), 64'h8B040086);

      step("rd_st", 0, 1, 1, 8'h0B, 1);
      chk("rd_st.valid", 64'(id_valid), 64'h0);
      chk("rd_st.addr", 64'(imem_addr), 64'h2);
      step("rd_st_f", 0, 0, 0, 8'h00, 1);
      chk("rd_st_f.instr", 64'(id_instr), 64'h8B040086);
      chk("rd_st_f.idpc", 64'(id_pc), 64'h08);

      step("wrap_rd", 0, 0, 1, 8'hFC, 1);
      step("wrap_a", 0, 0, 0, 8'h00, 1);
      chk("wrap_a.idpc", 64'(id_pc), 64'hFC);
      step("wrap_b", 0, 0, 0, 8'h00, 1);
      chk("wrap_b.idpc", 64'(id_pc), 64'h00);
      chk("wrap_b.instr", 64'(id_instr), 64'h8B1F03E5);

      // Async reset between edges while a word is live.
      chk("pre_arst.valid", 64'(id_valid), 64'h1);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst.valid", 64'(id_valid), 64'h0);
      chk("arst.instr", 64'(id_instr), 64'h0);
      chk("arst.halted", 64'(halted), 64'h0);
      chk("arst.addr", 64'(imem_addr), 64'h0);
      @(negedge clk); rst_n = 1'b1;
      step("arst_idle", 0, 0, 0, 8'h00, 1);
      step("arst_idle2", 0, 0, 0, 8'h00, 1);
      step("arst_start", 1, 0, 0, 8'h00, 1);
      step("arst_f0", 0, 0, 0, 8'h00, 1);

      // Randomized traffic over a fresh memory image.
      @(negedge clk); rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 64; i++)
         mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 800; i++) begin
         step("rnd",
              logic'($urandom_range(0, 9) == 0),
              logic'($urandom_range(0, 4) == 0),
              logic'($urandom_range(0, 12) == 0),
              8'($urandom),
              logic'($urandom_range(0, 9) < 7));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
